fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain_pkg.sv | 15 +
 rtl/fifo_drain.sv | 133 +++++++++++++
 tb/tb_fifo_drain.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and default constants for the FIFO read-side drain controller.
package fifo_drain_pkg;

    // Two-bit state encoding; SPARE is never entered and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        OFFER     = 2'b01,
        WAIT_DONE = 2'b10,
        SPARE     = 2'b11
    } drain_state_e;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/fifo_drain.sv
// fifo_drain: pops one word at a time from the read side of a FIFO and offers
// it to a downstream serializer, holding it until the serializer has been
// busy with it and has finished.
//
// Optional feature macro: FIFO_DRAIN_TIMEOUT_EN
//   defined   -> TIMEOUT port exists; a word offered for TIMEOUT_CYCLES cycles
//                without BUSY rising is dropped with a one-cycle TIMEOUT pulse.
//   undefined -> no TIMEOUT port, no counter; OFFER waits for BUSY forever.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no word held; pop as soon as the FIFO is not empty
// OFFER     | word held in P_DATA, DATA_VALID high, waiting for BUSY
// WAIT_DONE | serializer took the word; waiting for BUSY to fall
// SPARE     | unused encoding, returns to IDLE
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    input  logic                  BUSY,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID
`ifdef FIFO_DRAIN_TIMEOUT_EN
    ,
    output logic                  TIMEOUT
`endif
);

    drain_state_e state;
    drain_state_e state_next;
    logic         pop;
    logic         timeout_hit;

    // Reject nonsensical configurations at elaboration.
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_drain: DATA_WIDTH must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fifo_drain: TIMEOUT_CYCLES must be at least 1");
    end

    // A pop while RST is low would be lost (P_DATA cannot load during reset),
    // so the pop request is also held off by reset.
    assign pop   = RST && (state == IDLE) && !EMPTY;
    assign R_INC = pop;

`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] offer_cnt;

    // Count cycles spent in OFFER; the count is zero on the first OFFER cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            offer_cnt <= '0;
        end else if (state != OFFER) begin
            offer_cnt <= '0;
        end else begin
            offer_cnt <= offer_cnt + CNT_W'(1);
        end
    end

    // Terminal count reached in the last allowed OFFER cycle with no taker.
    assign timeout_hit = (state == OFFER) && !BUSY &&
                         (offer_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign TIMEOUT     = timeout_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state decode; BUSY takes priority over a coincident timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (BUSY) begin
                    state_next = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!BUSY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the FIFO word on the pop edge; hold it at all other times.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA <= '0;
        end else if (pop) begin
            P_DATA <= RD_DATA;
        end
    end

    // DATA_VALID is a flop that mirrors "next state is OFFER", so it is high
    // exactly while the state register holds OFFER, without decode glitches.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= (state_next == OFFER);
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a queue-backed FIFO, a transaction-level model of the
// drain protocol checked every cycle, and directed scenarios with literal
// expectations. Build with +define+FIFO_DRAIN_TIMEOUT_EN to cover the timeout.
module tb_fifo_drain;

    localparam int DW = 8;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int TC    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TC    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          empty   = 1'b1;
    logic          busy    = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          r_inc;
    logic [DW-1:0] p_data;
    logic          data_valid;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    fifo_drain #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .EMPTY      (empty),
        .RD_DATA    (rd_data),
        .R_INC      (r_inc),
        .BUSY       (busy),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid)
`ifdef FIFO_DRAIN_TIMEOUT_EN
        ,
        .TIMEOUT    (timeout)
`endif
    );

    int test_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO emulation (registered EMPTY) ----------------
    logic [DW-1:0] fifo_q[$];
    bit            pop_req   = 1'b0;
    int            r_inc_cnt = 0;

    always @(negedge clk) begin
        pop_req = (r_inc === 1'b1);
        if (r_inc === 1'b1) r_inc_cnt++;
    end

    always @(posedge clk) begin
        if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        empty   = (fifo_q.size() == 0);
        rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    end

    // ---------------- transaction-level model ----------------
    // have: a word is held; acc: the serializer has taken it (BUSY seen);
    // age: number of offer cycles already spent without a taker.
    bit            m_have = 1'b0;
    bit            m_acc  = 1'b0;
    logic [DW-1:0] m_word = '0;
    int            m_age  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_have = 1'b0; m_acc = 1'b0; m_word = '0; m_age = 0;
        end else if (!m_have) begin
            if (!empty) begin
                m_have = 1'b1; m_acc = 1'b0; m_word = rd_data; m_age = 0;
            end
        end else if (!m_acc) begin
            if (busy) m_acc = 1'b1;
            else if (TO_EN && m_age == TC - 1) m_have = 1'b0;
            else m_age++;
        end else if (!busy) begin
            m_have = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic          exp_inc, exp_dv, exp_to;
        logic [DW-1:0] exp_pd;
        if (!rst_n) begin
            exp_inc = 1'b0; exp_dv = 1'b0; exp_to = 1'b0; exp_pd = '0;
        end else begin
            exp_inc = !m_have && !empty;
            exp_dv  = m_have && !m_acc;
            exp_pd  = m_word;
            exp_to  = TO_EN && m_have && !m_acc && !busy && (m_age == TC - 1);
        end
        check("model_r_inc", {31'b0, r_inc}, {31'b0, exp_inc});
        check("model_data_valid", {31'b0, data_valid}, {31'b0, exp_dv});
        check("model_p_data", {24'b0, p_data}, {24'b0, exp_pd});
`ifdef FIFO_DRAIN_TIMEOUT_EN
        check("model_timeout", {31'b0, timeout}, {31'b0, exp_to});
`else
        check("model_timeout_off", {31'b0, exp_to}, 32'd0 + {31'b0, busy & 1'b0});
`endif
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            at_neg();
            if (data_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check(name, {31'b0, got}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 100000", $time);
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int            base;
        bit            seen;
        logic [DW-1:0] s2_words[3];
        s2_words[0] = 8'h11;
        s2_words[1] = 8'h22;
        s2_words[2] = 8'h33;

        // Reset state
        repeat (3) tick();
        at_neg();
        check("rst_data_valid", {31'b0, data_valid}, 32'd0);
        check("rst_p_data", {24'b0, p_data}, 32'd0);
        check("rst_r_inc", {31'b0, r_inc}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single word 0xA5
        base = r_inc_cnt;
        fifo_q.push_back(8'hA5);
        wait_valid("s1_wait_valid", 10);
        check("s1_p_data", {24'b0, p_data}, 32'hA5);
        check("s1_one_pulse", r_inc_cnt - base, 32'd1);
        tick(); busy = 1'b1;
        tick(); tick(); busy = 1'b0;
        repeat (3) tick();
        at_neg();
        check("s1_idle_dv", {31'b0, data_valid}, 32'd0);
        check("s1_total_pulses", r_inc_cnt - base, 32'd1);

        // Back-to-back words, BUSY held 10 cycles each
        tick();
        base = r_inc_cnt;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        for (int i = 0; i < 3; i++) begin
            wait_valid("s2_wait_valid", 10);
            check("s2_p_data_order", {24'b0, p_data}, {24'b0, s2_words[i]});
            check("s2_single_pending", r_inc_cnt - base, i + 1);
            tick(); busy = 1'b1;
            repeat (10) tick();
            busy = 1'b0;
        end
        repeat (3) tick();
        at_neg();
        check("s2_three_pulses", r_inc_cnt - base, 32'd3);

        // Early BUSY: one-cycle offer, EMPTY ignored while held
        tick();
        busy = 1'b1;
        base = r_inc_cnt;
        fifo_q.push_back(8'h5C);
        wait_valid("s3_wait_valid", 10);
        check("s3_p_data", {24'b0, p_data}, 32'h5C);
        tick(); at_neg();
        check("s3_one_cycle_offer", {31'b0, data_valid}, 32'd0);
        fifo_q.push_back(8'h77);
        repeat (5) begin tick(); at_neg(); end
        check("s3_no_pop_while_held", r_inc_cnt - base, 32'd1);
        check("s3_p_data_hold", {24'b0, p_data}, 32'h5C);
        tick(); busy = 1'b0;
        wait_valid("s3_second_valid", 10);
        check("s3_second_p_data", {24'b0, p_data}, 32'h77);
        check("s3_two_pulses", r_inc_cnt - base, 32'd2);
        tick(); busy = 1'b1;
        tick(); busy = 1'b0;
        repeat (3) tick();

        // Reset during WAIT_DONE
        base = r_inc_cnt;
        fifo_q.push_back(8'h3C);
        wait_valid("s4_wait_valid", 10);
        tick(); busy = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        at_neg();
        check("s4_rst_dv", {31'b0, data_valid}, 32'd0);
        check("s4_rst_p_data", {24'b0, p_data}, 32'd0);
        tick();
        busy  = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) begin tick(); at_neg(); end
        check("s4_no_pop_after_rst", r_inc_cnt - base, 32'd1);
        check("s4_dv_after_rst", {31'b0, data_valid}, 32'd0);

`ifdef FIFO_DRAIN_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=4, BUSY held low
        tick();
        base = r_inc_cnt;
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'h82);
        wait_valid("s5_wait_valid", 10);
        check("s5_p_data", {24'b0, p_data}, 32'h81);
        tick(); at_neg();
        tick(); at_neg();
        check("s5_no_early_timeout", {31'b0, timeout}, 32'd0);
        tick(); at_neg();
        check("s5_timeout_4th_cycle", {31'b0, timeout}, 32'd1);
        check("s5_dv_in_4th_cycle", {31'b0, data_valid}, 32'd1);
        tick(); at_neg();
        check("s5_dv_dropped", {31'b0, data_valid}, 32'd0);
        check("s5_timeout_one_cycle", {31'b0, timeout}, 32'd0);
        check("s5_next_pop", {31'b0, r_inc}, 32'd1);
        tick(); at_neg();
        check("s5_next_valid", {31'b0, data_valid}, 32'd1);
        check("s5_next_p_data", {24'b0, p_data}, 32'h82);
        check("s5_pulses", r_inc_cnt - base, 32'd2);
        tick(); busy = 1'b1;
        tick(); busy = 1'b0;
        repeat (3) tick();
`else
        // No timeout: the offer waits for BUSY indefinitely
        tick();
        fifo_q.push_back(8'h9E);
        wait_valid("s5_wait_valid", 10);
        seen = 1'b0;
        repeat (20) begin
            tick(); at_neg();
            if (data_valid !== 1'b1) seen = 1'b1;
        end
        check("s5_offer_held", {31'b0, seen}, 32'd0);
        check("s5_p_data", {24'b0, p_data}, 32'h9E);
        tick(); busy = 1'b1;
        tick(); busy = 1'b0;
        repeat (3) tick();
`endif

        // EMPTY stuck high for 100 cycles
        base = r_inc_cnt;
        seen = 1'b0;
        repeat (100) begin
            tick(); at_neg();
            if (data_valid !== 1'b0 || r_inc !== 1'b0) seen = 1'b1;
        end
        check("s6_no_pop", r_inc_cnt - base, 32'd0);
        check("s6_quiet", {31'b0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
